// File: rtl/move_ctrl.sv
// Tic-tac-toe move controller: validates a requested cell, issues a one-cycle
// write enable to the position register, then settles win/draw/turn state.
module move_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic       game_won,
  output logic [8:0] playX_pos_en,
  output logic [8:0] play0_pos_en,
  output logic       ready,
  output logic       turn_x,
  output logic       illegal_move,
  output logic [3:0] move_count,
  output logic [1:0] result,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, CHECK, COMMIT, SETTLE, OVER} state_t;

  state_t          state;
  logic [3:0]      req_pos;
  logic [8:0][1:0] board;

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  // A request is playable only if it names a real cell that is still empty.
  function automatic logic cell_free(input logic [8:0][1:0] b, input logic [3:0] p);
    logic [3:0] idx;
    idx = p - 4'd1;
    if (p == 4'd0 || p > 4'd9)
      return 1'b0;
    return b[idx] == 2'b00;
  endfunction

  function automatic logic [8:0] cell_onehot(input logic [3:0] p);
    return 9'd1 << (p - 4'd1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_pos      <= 4'd0;
      turn_x       <= 1'b1;
      move_count   <= 4'd0;
      result       <= 2'b00;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      ready        <= 1'b1;
      playX_pos_en <= 9'd0;
      play0_pos_en <= 9'd0;
    end else begin
      illegal_move <= 1'b0;
      playX_pos_en <= 9'd0;
      play0_pos_en <= 9'd0;
      case (state)
        IDLE: begin
          if (move_valid) begin
            req_pos <= move_pos;
            ready   <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (cell_free(board, req_pos)) begin
            // Enable is registered here so it is visible for the whole COMMIT cycle.
            if (turn_x)
              playX_pos_en <= cell_onehot(req_pos);
            else
              play0_pos_en <= cell_onehot(req_pos);
            state <= COMMIT;
          end else begin
            illegal_move <= 1'b1;
            ready        <= 1'b1;
            state        <= IDLE;
          end
        end
        COMMIT: begin
          move_count <= (move_count >= 4'd9) ? 4'd9 : move_count + 4'd1;
          state      <= SETTLE;
        end
        SETTLE: begin
          // Board now holds the committed move; a win outranks a full board.
          if (game_won) begin
            result    <= turn_x ? 2'b01 : 2'b10;
            game_over <= 1'b1;
            state     <= OVER;
          end else if (move_count == 4'd9) begin
            result    <= 2'b11;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            turn_x <= ~turn_x;
            ready  <= 1'b1;
            state  <= IDLE;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: a tb-side position register closes the loop, and a
// game-level model predicts enables, pulses, latency and final state per move.
module tb_move_ctrl;

  logic       clk;
  logic       rst;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       game_won;
  logic [8:0] playX_pos_en;
  logic [8:0] play0_pos_en;
  logic       ready;
  logic       turn_x;
  logic       illegal_move;
  logic [3:0] move_count;
  logic [1:0] result;
  logic       game_over;

  logic [8:0][1:0] board;

  int checks;
  int failures;

  // Model of the game, kept in rules-level terms.
  logic [8:0][1:0] mb;
  bit              m_turn_x;
  int              m_count;
  logic [1:0]      m_result;

  localparam int LN [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

  move_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .move_valid   (move_valid),
    .move_pos     (move_pos),
    .pos1         (board[0]),
    .pos2         (board[1]),
    .pos3         (board[2]),
    .pos4         (board[3]),
    .pos5         (board[4]),
    .pos6         (board[5]),
    .pos7         (board[6]),
    .pos8         (board[7]),
    .pos9         (board[8]),
    .game_won     (game_won),
    .playX_pos_en (playX_pos_en),
    .play0_pos_en (play0_pos_en),
    .ready        (ready),
    .turn_x       (turn_x),
    .illegal_move (illegal_move),
    .move_count   (move_count),
    .result       (result),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic line_win(input logic [8:0][1:0] b);
    for (int l = 0; l < 8; l++) begin
      if (b[LN[3*l]] != 2'b00 && b[LN[3*l]] == b[LN[3*l+1]] && b[LN[3*l]] == b[LN[3*l+2]])
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Position register: shares rst with the controller.
  always_ff @(posedge clk) begin
    if (rst)
      board <= '0;
    else
      for (int i = 0; i < 9; i++) begin
        if (playX_pos_en[i])
          board[i] <= 2'b01;
        else if (play0_pos_en[i])
          board[i] <= 2'b10;
      end
  end

  always_comb game_won = line_win(board);

  task automatic model_reset();
    mb       = '0;
    m_turn_x = 1'b1;
    m_count  = 0;
    m_result = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Presents one request, watches six cycles, and compares with the model.
  task automatic play_and_check(input logic [3:0] p, input string tag);
    bit         over_before, legal;
    int         idx, en_cycles, ill_cycles, lat, exp_lat;
    logic [8:0] exp_x, exp_o, seen_x, seen_o;
    over_before = (m_result != 2'b00);
    idx   = int'(p) - 1;
    legal = !over_before && p >= 4'd1 && p <= 4'd9 && mb[idx] == 2'b00;
    exp_x = '0;
    exp_o = '0;
    if (legal) begin
      if (m_turn_x) begin
        exp_x   = 9'd1 << idx;
        mb[idx] = 2'b01;
      end else begin
        exp_o   = 9'd1 << idx;
        mb[idx] = 2'b10;
      end
      m_count = (m_count >= 9) ? 9 : m_count + 1;
      if (line_win(mb))
        m_result = m_turn_x ? 2'b01 : 2'b10;
      else if (m_count == 9)
        m_result = 2'b11;
      else
        m_turn_x = !m_turn_x;
    end
    exp_lat = legal ? 4 : 2;

    @(negedge clk);
    move_valid = 1'b1;
    move_pos   = p;
    @(posedge clk);
    en_cycles = 0; ill_cycles = 0; lat = 0; seen_x = '0; seen_o = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) move_valid = 1'b0;
      seen_x |= playX_pos_en;
      seen_o |= play0_pos_en;
      if ((playX_pos_en | play0_pos_en) != 9'd0) en_cycles++;
      if (illegal_move) ill_cycles++;
      if (lat == 0 && (ready || game_over)) lat = k;
    end

    checks++;
    if (seen_x !== exp_x) begin
      failures++; $display("FAIL %s x_en pos=%0d got=%h want=%h", tag, p, seen_x, exp_x);
    end
    checks++;
    if (seen_o !== exp_o) begin
      failures++; $display("FAIL %s o_en pos=%0d got=%h want=%h", tag, p, seen_o, exp_o);
    end
    checks++;
    if (en_cycles != (legal ? 1 : 0)) begin
      failures++; $display("FAIL %s en_cycles pos=%0d got=%0d want=%0d", tag, p, en_cycles, legal ? 1 : 0);
    end
    checks++;
    if (ill_cycles != ((!legal && !over_before) ? 1 : 0)) begin
      failures++; $display("FAIL %s illegal_pulses pos=%0d got=%0d want=%0d", tag, p, ill_cycles,
                           (!legal && !over_before) ? 1 : 0);
    end
    if (!over_before) begin
      checks++;
      if (lat != exp_lat) begin
        failures++; $display("FAIL %s latency pos=%0d got=%0d want=%0d", tag, p, lat, exp_lat);
      end
    end
    checks++;
    if (turn_x !== m_turn_x) begin
      failures++; $display("FAIL %s turn_x got=%b want=%b", tag, turn_x, m_turn_x);
    end
    checks++;
    if (move_count !== 4'(m_count)) begin
      failures++; $display("FAIL %s move_count got=%0d want=%0d", tag, move_count, m_count);
    end
    checks++;
    if (result !== m_result) begin
      failures++; $display("FAIL %s result got=%b want=%b", tag, result, m_result);
    end
    checks++;
    if (game_over !== (m_result != 2'b00)) begin
      failures++; $display("FAIL %s game_over got=%b want=%b", tag, game_over, m_result != 2'b00);
    end
    checks++;
    if (ready !== (m_result == 2'b00)) begin
      failures++; $display("FAIL %s ready got=%b want=%b", tag, ready, m_result == 2'b00);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ready, turn_x, illegal_move, game_over} !== 4'b1100) begin
      failures++; $display("FAIL reset flags got=%b want=1100", {ready, turn_x, illegal_move, game_over});
    end
    checks++;
    if (move_count !== 4'd0 || result !== 2'b00) begin
      failures++; $display("FAIL reset count_result got=%0d/%b want=0/00", move_count, result);
    end
    checks++;
    if (playX_pos_en !== 9'd0 || play0_pos_en !== 9'd0) begin
      failures++; $display("FAIL reset enables got=%h/%h want=0/0", playX_pos_en, play0_pos_en);
    end
  endtask

  task automatic test_first_move_and_occupied();
    apply_reset();
    play_and_check(4'd5, "first_move");
    checks++;
    if (turn_x !== 1'b0 || move_count !== 4'd1) begin
      failures++; $display("FAIL first_move_state got=%b/%0d want=0/1", turn_x, move_count);
    end
    play_and_check(4'd5, "occupied");
  endtask

  task automatic test_out_of_range();
    play_and_check(4'd0, "pos_zero");
    play_and_check(4'd12, "pos_twelve");
  endtask

  task automatic test_x_win();
    logic [3:0] seq [5] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
    apply_reset();
    for (int i = 0; i < 5; i++) play_and_check(seq[i], "x_win");
    checks++;
    if (result !== 2'b01 || game_over !== 1'b1) begin
      failures++; $display("FAIL x_win_final got=%b/%b want=01/1", result, game_over);
    end
    play_and_check(4'd9, "after_over");
  endtask

  task automatic test_draw();
    logic [3:0] seq [9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
    apply_reset();
    for (int i = 0; i < 9; i++) play_and_check(seq[i], "draw");
    checks++;
    if (move_count !== 4'd9 || result !== 2'b11 || game_over !== 1'b1) begin
      failures++; $display("FAIL draw_final got=%0d/%b/%b want=9/11/1", move_count, result, game_over);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (playX_pos_en !== 9'd0 || play0_pos_en !== 9'd0 || ready !== 1'b1 || turn_x !== 1'b1 ||
        move_count !== 4'd0 || result !== 2'b00 || illegal_move !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL %s got en=%h/%h rdy=%b tx=%b cnt=%0d res=%b ill=%b over=%b want reset values",
               tag, playX_pos_en, play0_pos_en, ready, turn_x, move_count, result, illegal_move, game_over);
    end
  endtask

  task automatic test_reset_mid_move();
    apply_reset();
    // Reset lands on the edge that would open COMMIT.
    @(negedge clk);
    move_valid = 1'b1; move_pos = 4'd5;
    @(negedge clk);
    move_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_enter_commit");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_enter_commit_next");
    // Reset asserted while COMMIT is already showing its enable.
    @(negedge clk);
    move_valid = 1'b1; move_pos = 4'd3;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_in_commit");
    rst = 1'b0;
    model_reset();
    play_and_check(4'd3, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int g = 0; g < 4; g++) begin
      apply_reset();
      for (int m = 0; m < 24; m++)
        play_and_check(4'($urandom_range(0, 11)), "random");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; move_valid = 1'b0; move_pos = 4'd0;
    model_reset();
    test_reset();
    test_first_move_and_occupied();
    test_out_of_range();
    test_x_win();
    test_draw();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
